// File: rtl/lampfpu_sqrt_seq.sv
// Sequencer around an external fractional square-root core: classifies the operand,
// prepares the core mantissa and exponent, then normalises and rounds the core result.
`timescale 1ns/1ps

module lampfpu_sqrt_seq #(
    parameter int F_DW    = 7,
    parameter int E_DW    = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                doSqrt_i,
    input  logic                doInvSqrt_i,
    input  logic [E_DW+F_DW:0]  op_i,
    output logic [E_DW+F_DW:0]  result_o,
    output logic                valid_o,
    output logic                busy_o,
    output logic                invalid_o,
    output logic                divByZero_o,
    output logic                core_doSqrt_o,
    output logic                core_doInvSqrt_o,
    output logic [F_DW:0]       core_s_o,
    input  logic [2*F_DW+1:0]   core_result_i,
    input  logic                core_valid_i
);

    localparam int W    = 1 + E_DW + F_DW;
    localparam int RW   = 2*F_DW + 2;
    localparam int XW   = E_DW + 2;
    localparam int BIAS = (1 << (E_DW-1)) - 1;

    localparam logic [4:0]   TO_CNT = 5'(TIMEOUT);
    localparam logic [W-1:0] QNAN   = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [W-1:0] PINF   = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ROUND, SPEC} state_t;

    state_t            state_reg, state_next;
    logic              inv_reg, inv_next;
    logic [F_DW:0]     core_s_reg, core_s_next;
    logic [E_DW-1:0]   exp_reg, exp_next;
    logic [RW-1:0]     res_reg, res_next;
    logic [4:0]        cnt_reg, cnt_next;
    logic [W-1:0]      result_reg, result_next;
    logic              valid_reg, valid_next;
    logic              invalid_reg, invalid_next;
    logic              dbz_reg, dbz_next;

    // Operand classification
    logic              op_sign;
    logic [E_DW-1:0]   op_exp;
    logic [F_DW-1:0]   op_frac;
    logic              exp_ones, exp_zero, is_nan, is_special;
    logic              req_any, req_inv;

    assign op_sign    = op_i[W-1];
    assign op_exp     = op_i[W-2 -: E_DW];
    assign op_frac    = op_i[F_DW-1:0];
    assign exp_ones   = &op_exp;
    assign exp_zero   = ~|op_exp;
    assign is_nan     = exp_ones & (|op_frac);
    assign is_special = exp_ones | exp_zero | op_sign;
    assign req_any    = doSqrt_i | doInvSqrt_i;
    assign req_inv    = ~doSqrt_i & doInvSqrt_i;

    logic [W-1:0] spec_result;
    logic         spec_invalid, spec_dbz;

    always_comb begin
        spec_result  = '0;
        spec_invalid = 1'b0;
        spec_dbz     = 1'b0;
        if (is_nan) begin
            spec_result  = QNAN;
            spec_invalid = 1'b1;
        end else if (exp_zero) begin
            // Denormals are flushed, so they behave exactly like a signed zero
            if (req_inv) begin
                spec_result = PINF;
                spec_dbz    = 1'b1;
            end else begin
                spec_result = {op_sign, {(W-1){1'b0}}};
            end
        end else if (op_sign) begin
            spec_result  = QNAN;
            spec_invalid = 1'b1;
        end else begin
            spec_result = req_inv ? '0 : PINF;
        end
    end

    // Odd biased exponent means an even unbiased one, so the mantissa goes in as 1.M;
    // otherwise it is pre-halved to 0.1M so the exponent halves exactly.
    logic [XW-1:0]   exp_ext, sqrt_sum, inv_diff;
    logic [E_DW-1:0] exp_init;
    logic [F_DW:0]   core_s_init;

    assign exp_ext     = XW'(op_exp);
    assign sqrt_sum    = exp_ext + XW'(op_exp[0] ? BIAS : BIAS + 1);
    assign inv_diff    = XW'(op_exp[0] ? 3*BIAS : 3*BIAS - 1) - exp_ext;
    assign exp_init    = req_inv ? inv_diff[E_DW:1] : sqrt_sum[E_DW:1];
    assign core_s_init = op_exp[0] ? {1'b1, op_frac} : {2'b01, op_frac[F_DW-1:1]};

    // Normalisation and round-to-nearest-even of the captured core result
    logic            hi, guard, sticky, round_up, carry;
    logic [F_DW-1:0] mant_pre, mant_rnd;
    logic [E_DW-1:0] exp_adj, exp_fin;

    assign hi       = res_reg[RW-1];
    assign mant_pre = hi ? res_reg[RW-2 -: F_DW] : res_reg[RW-3 -: F_DW];
    assign guard    = hi ? res_reg[RW-2-F_DW] : res_reg[RW-3-F_DW];
    assign sticky   = hi ? (|res_reg[RW-3-F_DW:0]) : (|res_reg[RW-4-F_DW:0]);
    assign round_up = guard & (sticky | mant_pre[0]);
    assign {carry, mant_rnd} = {1'b0, mant_pre} + {{F_DW{1'b0}}, round_up};
    assign exp_adj  = hi ? exp_reg : exp_reg - E_DW'(1);
    assign exp_fin  = exp_adj + {{(E_DW-1){1'b0}}, carry};

    always_comb begin
        state_next   = state_reg;
        inv_next     = inv_reg;
        core_s_next  = core_s_reg;
        exp_next     = exp_reg;
        res_next     = res_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        valid_next   = 1'b0;
        invalid_next = invalid_reg;
        dbz_next     = dbz_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_any) begin
                    if (is_special) begin
                        state_next   = SPEC;
                        result_next  = spec_result;
                        invalid_next = spec_invalid;
                        dbz_next     = spec_dbz;
                        valid_next   = 1'b1;
                    end else begin
                        state_next  = ISSUE;
                        inv_next    = req_inv;
                        core_s_next = core_s_init;
                        exp_next    = exp_init;
                    end
                end
            end
            SPEC: begin
                state_next = IDLE;
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
            WAIT: begin
                cnt_next = cnt_reg + 5'd1;
                if (core_valid_i) begin
                    state_next = ROUND;
                    res_next   = core_result_i;
                end else if (cnt_reg + 5'd1 == TO_CNT) begin
                    state_next   = IDLE;
                    result_next  = QNAN;
                    invalid_next = 1'b1;
                    dbz_next     = 1'b0;
                    valid_next   = 1'b1;
                end
            end
            ROUND: begin
                state_next   = IDLE;
                result_next  = {1'b0, exp_fin, mant_rnd};
                invalid_next = 1'b0;
                dbz_next     = 1'b0;
                valid_next   = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            inv_reg     <= 1'b0;
            core_s_reg  <= '0;
            exp_reg     <= '0;
            res_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            invalid_reg <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            inv_reg     <= inv_next;
            core_s_reg  <= core_s_next;
            exp_reg     <= exp_next;
            res_reg     <= res_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            valid_reg   <= valid_next;
            invalid_reg <= invalid_next;
            dbz_reg     <= dbz_next;
        end
    end

    assign result_o         = result_reg;
    assign valid_o          = valid_reg;
    assign invalid_o        = invalid_reg;
    assign divByZero_o      = dbz_reg;
    assign busy_o           = (state_reg != IDLE);
    assign core_doSqrt_o    = (state_reg == ISSUE) & ~inv_reg;
    assign core_doInvSqrt_o = (state_reg == ISSUE) & inv_reg;
    assign core_s_o         = core_s_reg;

endmodule

// File: tb/tb_lampfpu_sqrt_seq.sv
// Bench for lampfpu_sqrt_seq: directed cases plus random operands against a
// value-level reference model, with a scripted stub core of programmable latency.
`timescale 1ns/1ps

module tb_lampfpu_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        doSqrt_i, doInvSqrt_i;
    logic [15:0] op_i;
    logic [15:0] result_o;
    logic        valid_o, busy_o, invalid_o, divByZero_o;
    logic        core_doSqrt_o, core_doInvSqrt_o;
    logic [7:0]  core_s_o;
    logic [15:0] core_result_i;
    logic        core_valid_i;

    int total = 0;
    int bad   = 0;

    lampfpu_sqrt_seq #(.F_DW(7), .E_DW(8), .TIMEOUT(31)) dut (
        .clk(clk), .rst(rst),
        .doSqrt_i(doSqrt_i), .doInvSqrt_i(doInvSqrt_i), .op_i(op_i),
        .result_o(result_o), .valid_o(valid_o), .busy_o(busy_o),
        .invalid_o(invalid_o), .divByZero_o(divByZero_o),
        .core_doSqrt_o(core_doSqrt_o), .core_doInvSqrt_o(core_doInvSqrt_o),
        .core_s_o(core_s_o), .core_result_i(core_result_i), .core_valid_i(core_valid_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: operand = 1.M * 2^u; the core sees s in [0.5,2) and returns sqrt(s) or
    // 1/sqrt(s) in Q1.15, so the answer is R * 2^k, normalised generically and RNE-rounded.
    function automatic void model(input logic inv, input logic [15:0] op, input logic [15:0] r,
                                  output logic [15:0] res, output logic fi, output logic fd,
                                  output logic special, output logic [7:0] cs);
        int e, m, u, k, pos, keep, rem, half, be;
        e = int'(op[14:7]);
        m = int'(op[6:0]);
        fi = 1'b0; fd = 1'b0; special = 1'b1; cs = 8'h00; res = 16'h0000;
        if (e == 255 && m != 0) begin
            res = 16'h7FC0; fi = 1'b1;
        end else if (e == 0) begin
            if (inv) begin res = 16'h7F80; fd = 1'b1; end
            else res = {op[15], 15'b0};
        end else if (op[15]) begin
            res = 16'h7FC0; fi = 1'b1;
        end else if (e == 255) begin
            res = inv ? 16'h0000 : 16'h7F80;
        end else begin
            special = 1'b0;
            u = e - 127;
            if (e % 2 == 1) begin
                cs = 8'(128 + m);
                k  = u / 2;
            end else begin
                cs = 8'((128 + m) / 2);
                k  = (u + 1) / 2;
            end
            if (inv) k = -k;
            pos = 15;
            while (pos > 8 && !r[pos]) pos--;
            keep = int'(r) >> (pos - 7);
            rem  = int'(r) & ((1 << (pos - 7)) - 1);
            half = 1 << (pos - 8);
            if (rem > half || (rem == half && (keep % 2) == 1)) keep++;
            be = 127 + k + (pos - 15);
            if (keep == 256) begin keep = 128; be++; end
            res = {1'b0, 8'(be), 7'(keep)};
        end
    endfunction

    // Issues one request and plays the stub core; lat < 0 means the core never answers.
    task automatic run_op(input logic inv, input logic [15:0] op, input int lat, input logic [15:0] r,
                          output logic [15:0] res, output logic fi, output logic fd, output int vcyc,
                          output int nsq, output int ninv, output logic [7:0] cs,
                          output logic cs_stable, output logic busy_at_v, output logic v_again,
                          output logic held);
        int req_cyc;
        req_cyc = -1; vcyc = -1; nsq = 0; ninv = 0; cs = 8'h00; cs_stable = 1'b1;
        busy_at_v = 1'b0; v_again = 1'b0; held = 1'b0; res = 16'h0; fi = 1'b0; fd = 1'b0;
        @(negedge clk);
        op_i = op; doSqrt_i = ~inv; doInvSqrt_i = inv; core_result_i = r;
        @(posedge clk);
        #1;
        doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; op_i = 16'($urandom);
        for (int kc = 1; kc <= 80; kc++) begin
            @(negedge clk);
            if (vcyc >= 0) begin
                v_again = valid_o;
                held    = (result_o === res);
                break;
            end
            if (core_doSqrt_o) nsq++;
            if (core_doInvSqrt_o) ninv++;
            if ((core_doSqrt_o || core_doInvSqrt_o) && req_cyc < 0) begin
                req_cyc = kc;
                cs = core_s_o;
            end else if (req_cyc >= 0 && busy_o && core_s_o !== cs) begin
                cs_stable = 1'b0;
            end
            if (valid_o) begin
                vcyc = kc; res = result_o; fi = invalid_o; fd = divByZero_o; busy_at_v = busy_o;
            end
            core_valid_i = (lat >= 0 && req_cyc >= 0 && kc == req_cyc + lat);
        end
        core_valid_i = 1'b0;
    endtask

    task automatic check_op(input string tag, input logic inv, input logic [15:0] op, input int lat,
                            input logic [15:0] r, input logic [15:0] e_res, input logic e_fi,
                            input logic e_fd, input int e_vcyc, input int e_sq, input int e_inv,
                            input logic [7:0] e_cs, input logic normal);
        logic [15:0] res; logic fi, fd, cs_stable, busy_at_v, v_again, held;
        int vcyc, nsq, ninv; logic [7:0] cs;
        run_op(inv, op, lat, r, res, fi, fd, vcyc, nsq, ninv, cs, cs_stable, busy_at_v, v_again, held);
        $display("op %s: %s in=%h core=%h lat=%0d res=%h inv=%b dbz=%b at cycle %0d",
                 tag, inv ? "invsqrt" : "sqrt", op, r, lat, res, fi, fd, vcyc);
        chk({tag, "/result"}, 32'(res), 32'(e_res));
        chk({tag, "/invalid"}, 32'(fi), 32'(e_fi));
        chk({tag, "/divbyzero"}, 32'(fd), 32'(e_fd));
        chk({tag, "/latency"}, 32'(vcyc), 32'(e_vcyc));
        chk({tag, "/core_sqrt_pulses"}, 32'(nsq), 32'(e_sq));
        chk({tag, "/core_inv_pulses"}, 32'(ninv), 32'(e_inv));
        chk({tag, "/single_valid"}, 32'(v_again), 32'(0));
        chk({tag, "/result_hold"}, 32'(held), 32'(1));
        chk({tag, "/busy_at_valid"}, 32'(busy_at_v), 32'(e_vcyc == 1));
        if (normal) begin
            chk({tag, "/core_s"}, 32'(cs), 32'(e_cs));
            chk({tag, "/core_s_stable"}, 32'(cs_stable), 32'(1));
        end
    endtask

    initial begin
        logic        inv, efi, efd, espec, vseen;
        logic [15:0] op, r, eres;
        logic [7:0]  ecs;
        int          lat;

        rst = 1'b0; doSqrt_i = 1'b0; doInvSqrt_i = 1'b0; op_i = 16'h0;
        core_result_i = 16'h0; core_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset/result", 32'(result_o), 32'(0));
        chk("reset/valid", 32'(valid_o), 32'(0));
        chk("reset/busy", 32'(busy_o), 32'(0));
        chk("reset/flags", 32'({invalid_o, divByZero_o}), 32'(0));
        chk("reset/core_req", 32'({core_doSqrt_o, core_doInvSqrt_o}), 32'(0));
        chk("reset/core_s", 32'(core_s_o), 32'(0));

        check_op("sqrt4", 1'b0, 16'h4080, 12, 16'h8000, 16'h4000, 0, 0, 15, 1, 0, 8'h80, 1);
        check_op("sqrt2", 1'b0, 16'h4000, 5, 16'h5A82, 16'h3FB5, 0, 0, 8, 1, 0, 8'h40, 1);
        check_op("round_up", 1'b0, 16'h4080, 4, 16'h80C0, 16'h4001, 0, 0, 7, 1, 0, 8'h80, 1);
        check_op("round_carry", 1'b0, 16'h4080, 2, 16'hFFC0, 16'h4080, 0, 0, 5, 1, 0, 8'h80, 1);
        check_op("inv_zero", 1'b1, 16'h0000, 3, 16'h8000, 16'h7F80, 0, 1, 1, 0, 0, 8'h00, 0);
        check_op("sqrt_neg", 1'b0, 16'hC080, 3, 16'h8000, 16'h7FC0, 1, 0, 1, 0, 0, 8'h00, 0);
        check_op("inv_inf", 1'b1, 16'h7F80, 3, 16'h8000, 16'h0000, 0, 0, 1, 0, 0, 8'h00, 0);
        check_op("sqrt_negzero", 1'b0, 16'h8000, 3, 16'h8000, 16'h8000, 0, 0, 1, 0, 0, 8'h00, 0);
        check_op("timeout", 1'b0, 16'h4080, -1, 16'h0000, 16'h7FC0, 1, 0, 33, 1, 0, 8'h80, 1);

        // Reset while waiting on the core, then a late core answer must be ignored
        @(negedge clk);
        op_i = 16'h4080; doSqrt_i = 1'b1;
        @(posedge clk);
        #1 doSqrt_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst/busy", 32'(busy_o), 32'(0));
        chk("midrst/core_s", 32'(core_s_o), 32'(0));
        chk("midrst/result", 32'(result_o), 32'(0));
        chk("midrst/flags", 32'({invalid_o, divByZero_o}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        core_result_i = 16'h8000; core_valid_i = 1'b1;
        @(negedge clk);
        core_valid_i = 1'b0;
        vseen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (valid_o || busy_o) vseen = 1'b1;
        end
        chk("midrst/no_valid", 32'(vseen), 32'(0));
        check_op("post_rst", 1'b0, 16'h4080, 6, 16'h8000, 16'h4000, 0, 0, 9, 1, 0, 8'h80, 1);

        for (int i = 0; i < 40; i++) begin
            inv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) op = 16'($urandom);
            else op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
            r   = 16'($urandom_range(32'h4000, 32'hFFFF));
            lat = int'($urandom_range(1, 20));
            model(inv, op, r, eres, efi, efd, espec, ecs);
            check_op($sformatf("rnd%0d", i), inv, op, lat, r, eres, efi, efd,
                     espec ? 1 : 3 + lat, espec ? 0 : int'(!inv), espec ? 0 : int'(inv),
                     ecs, !espec);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lampfpu_sqrt_seq.md
LAMPFPU_SQRT_SEQ -- requirements
Module: lampfpu_sqrt_seq

Interface
REQ-001 SHALL have parameter F_DW, default 7: mantissa fraction width (16-bit float: 1 sign, 8 exponent, 7 fraction, bias 127).
REQ-002 SHALL have parameter E_DW, default 8: exponent width.
REQ-003 SHALL have parameter TIMEOUT, default 31: maximum cycles spent waiting for the core.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 doSqrt_i  in  1  request square root of op_i.
REQ-008 doInvSqrt_i  in  1  request inverse square root of op_i.
REQ-009 op_i  in  16  operand {sign, exp[7:0], frac[6:0]}; sampled only on acceptance.
REQ-010 result_o  out  16  packed result.
REQ-011 valid_o  out  1  one-cycle pulse; result_o and flags valid.
REQ-012 busy_o  out  1  high whenever the FSM is not in IDLE.
REQ-013 invalid_o  out  1  invalid-operation flag, qualified by valid_o.
REQ-014 divByZero_o  out  1  divide-by-zero flag, qualified by valid_o.
REQ-015 core_doSqrt_o, core_doInvSqrt_o  out  1 each  request pulses to the fractional sqrt core.
REQ-016 core_s_o  out  8  core mantissa operand, 1.xxxxxxx or 0.1xxxxxx format.
REQ-017 core_result_i  in  16  core result, x.xxxxxxxxxxxxxxx (1 integer bit, 15 fraction bits).
REQ-018 core_valid_i  in  1  core result valid pulse.

Function
REQ-019 States: IDLE, ISSUE, WAIT, ROUND, with one additional SPEC state for special operands.
REQ-020 In IDLE, a request SHALL be accepted when doSqrt_i or doInvSqrt_i is high; doSqrt_i SHALL win when both are high. While busy_o is high, requests SHALL be ignored.
REQ-021 Special operands SHALL cause IDLE->SPEC, SPEC->IDLE, with valid_o asserted in SPEC (one cycle after acceptance). No core request SHALL be issued for special operands.
REQ-022 Special results:
- NaN, or negative nonzero (including -inf): 0x7FC0 with invalid_o.
- Exponent 0 (zero or denormal; denormals are flushed): sqrt gives signed zero {sign,15'b0}; invsqrt gives 0x7F80 with divByZero_o.
- +inf: sqrt gives 0x7F80; invsqrt gives 0x0000.
REQ-023 Normal operands SHALL cause IDLE->ISSUE, with biased exponent E, fraction M, and core_s_o registered at acceptance:
- E odd: core_s_o = {1,M}; sqrt exponent = (E+127)/2; invsqrt exponent = (381-E)/2.
- E even: core_s_o = {0,1,M[6:1]} (M[0] dropped); sqrt exponent = (E+128)/2; invsqrt exponent = (380-E)/2.
REQ-024 In ISSUE, exactly one of core_doSqrt_o/core_doInvSqrt_o SHALL be high for exactly one cycle, then ISSUE->WAIT.
REQ-025 core_s_o SHALL stay stable from ISSUE until the FSM returns to IDLE.
REQ-026 In WAIT, core_valid_i SHALL capture core_result_i and move to ROUND. core_valid_i outside WAIT SHALL be ignored.
REQ-027 A 5-bit wait counter SHALL clear on entry to WAIT. If it reaches TIMEOUT without core_valid_i, the block SHALL output 0x7FC0 with invalid_o, pulse valid_o, and return to IDLE.
REQ-028 ROUND normalisation, with R the captured core result:
- R[15]=1: mant = R[14:8], G = R[7], S = |R[6:0].
- R[15]=0: exponent decremented by 1; mant = R[13:7], G = R[6], S = |R[5:0].
REQ-029 Rounding SHALL be round-to-nearest-even: increment when G & (S | mant[0]). A carry out of mant SHALL zero mant and increment the exponent.
REQ-030 In ROUND, result_o = {0, exp, mant} SHALL be registered, valid_o pulsed, and the FSM returns to IDLE. Normal-path latency is acceptance + 3 + core latency cycles.
REQ-031 result_o and the flags SHALL hold their last values until the next valid_o; valid_o SHALL never be high for two consecutive cycles.

Reset
REQ-032 On rst low, the FSM SHALL go to IDLE immediately. All outputs, including core requests, core_s_o, and the counter, SHALL be 0 asynchronously.
REQ-033 Reset mid-operation SHALL abandon the operation with no valid_o. After reset release, a late core_valid_i SHALL be ignored.

Verification (stub core with programmable latency and result)
REQ-034 sqrt 0x4080 (4.0), stub returns 0x8000 after 12 cycles -> core_s_o=0x80, one core_doSqrt_o pulse, result_o=0x4000, valid_o 15 cycles after acceptance.
REQ-035 sqrt 0x4000 (2.0), stub returns 0x5A82 -> core_s_o=0x40, result_o=0x3FB5, no flags.
REQ-036 sqrt 0x4080, stub returns 0x80C0 -> result_o=0x4001 (round up).
REQ-037 Special operands, each with valid_o one cycle after acceptance and no core request:
- invsqrt 0x0000 -> 0x7F80, divByZero_o=1.
- sqrt 0xC080 -> 0x7FC0, invalid_o=1.
- invsqrt 0x7F80 -> 0x0000.
REQ-038 sqrt 0x4080 with the stub never responding -> 0x7FC0, invalid_o, valid_o after TIMEOUT cycles in WAIT; busy_o then low.
REQ-039 Reset asserted in WAIT, then the stub fires core_valid_i -> no valid_o; the next request completes normally.
